wb_sram_slave: RTL and testbench



---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_sram_slave_if.sv | 24 ++
 rtl/wb_sram_bram.sv | 46 ++++
 rtl/wb_sram_slave.sv | 136 +++++++++++++
 tb/tb_wb_sram_slave.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types, widths and byte-merge helper for the Wishbone SRAM slave
package wb_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_SEL_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_slave_state_t;

  function automatic logic [WB_DATA_WIDTH-1:0] wb_merge_bytes(
    input logic [WB_DATA_WIDTH-1:0] old_word,
    input logic [WB_DATA_WIDTH-1:0] new_word,
    input logic [WB_SEL_WIDTH-1:0]  sel
  );
    logic [WB_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < WB_SEL_WIDTH; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_sram_slave_if.sv
// rtl/wb_sram_slave_if.sv - Wishbone-classic bus bundle between a master and the SRAM slave
interface wb_sram_slave_if;

  logic                          wb_cyc_i;
  logic                          wb_stb_i;
  logic                          wb_we_i;
  logic [wb_pkg::WB_SEL_WIDTH-1:0]  wb_sel_i;
  logic [31:0]                   wb_addr_i;
  logic [wb_pkg::WB_DATA_WIDTH-1:0] wb_data_i;
  logic [wb_pkg::WB_DATA_WIDTH-1:0] wb_data_o;
  logic                          wb_ack_o;
  logic                          wb_err_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_addr_i, wb_data_i,
    output wb_data_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_addr_i, wb_data_i,
    input  wb_data_o, wb_ack_o, wb_err_o
  );

endinterface

// File: rtl/wb_sram_bram.sv
// rtl/wb_sram_bram.sv - single-port byte-enable word array with registered write-first read port
module wb_sram_bram
  import wb_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 12,
  parameter string MEMORY_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic                     clr,
  input  logic [WB_SEL_WIDTH-1:0]  sel,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [WB_DATA_WIDTH-1:0] wdata,
  output logic [WB_DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WB_DATA_WIDTH-1:0] mem [DEPTH];
  logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [WB_SEL_WIDTH-1:0]  lane_we;

  assign lane_we = (en && we) ? sel : '0;

  always_ff @(posedge clk) begin
    for (int b = 0; b < WB_SEL_WIDTH; b++) begin
      if (lane_we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Read port returns the post-write word so a write response carries the new contents.
  always_comb begin
    rdata_d = rdata_q;
    if (en) rdata_d = clr ? '0 : wb_merge_bytes(mem[addr], wdata, lane_we);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Wishbone-classic SRAM slave: request FSM, wait counter, decode, ack/err
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 12,
  parameter int    WAIT_STATES = 1,
  parameter string MEMORY_FILE = ""
) (
  input logic            sys_clk,
  input logic            rst_n,
  wb_sram_slave_if.slave wb
);

  localparam int CNT_W = 4;

  wb_slave_state_t          state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]    idx_q, idx_d;
  logic                     oor_q, oor_d;
  logic                     we_q, we_d;
  logic [WB_SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [WB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;

  logic                     req, bus_oor, enter_resp, use_bus;
  logic [ADDR_WIDTH-1:0]    bus_idx, acc_idx;
  logic                     acc_oor, acc_we;
  logic [WB_SEL_WIDTH-1:0]  acc_sel;
  logic [WB_DATA_WIDTH-1:0] acc_wdata;
  logic [1:0]               unused_addr_lsb;

  assign req             = wb.wb_cyc_i & wb.wb_stb_i;
  assign bus_idx         = wb.wb_addr_i[ADDR_WIDTH+1:2];
  assign bus_oor         = (wb.wb_addr_i >> (ADDR_WIDTH + 2)) != '0;
  assign unused_addr_lsb = wb.wb_addr_i[1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    oor_d      = oor_q;
    we_d       = we_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    use_bus    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = bus_idx;
          oor_d   = bus_oor;
          we_d    = wb.wb_we_i;
          sel_d   = wb.wb_sel_i;
          wdata_d = wb.wb_data_i;
          cnt_d   = CNT_W'(WAIT_STATES);
          // With no wait states the access happens on the sampling edge, straight from the bus.
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
            use_bus    = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb.wb_cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign acc_idx   = use_bus ? bus_idx       : idx_q;
  assign acc_oor   = use_bus ? bus_oor       : oor_q;
  assign acc_we    = use_bus ? wb.wb_we_i    : we_q;
  assign acc_sel   = use_bus ? wb.wb_sel_i   : sel_q;
  assign acc_wdata = use_bus ? wb.wb_data_i  : wdata_q;

  assign ack_d = enter_resp & ~acc_oor;
  assign err_d = enter_resp &  acc_oor;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Gating with rst_n keeps a zero-wait request held during reset from committing a write.
  wb_sram_bram #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .MEMORY_FILE (MEMORY_FILE)
  ) u_bram (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .en    (enter_resp & rst_n),
    .we    (acc_we & ~acc_oor),
    .clr   (acc_oor),
    .sel   (acc_sel),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (wb.wb_data_o)
  );

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - scoreboard bench for wb_sram_slave with 1, 0 and 3 wait states
module tb_wb_sram_slave;

  typedef struct {
    int          dut;
    bit          is_err;
    logic [31:0] data;
    int          at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cycle = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];

  logic [2:0]  cyc = '0, stb = '0, we = '0;
  logic [3:0]  sel [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  wire  [2:0]  ack, err;
  wire  [31:0] rdata [3];
  logic [2:0]  prev_resp = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    wb_sram_slave_if bus ();
    assign bus.wb_cyc_i  = cyc[g];
    assign bus.wb_stb_i  = stb[g];
    assign bus.wb_we_i   = we[g];
    assign bus.wb_sel_i  = sel[g];
    assign bus.wb_addr_i = addr[g];
    assign bus.wb_data_i = wdata[g];
    assign ack[g]        = bus.wb_ack_o;
    assign err[g]        = bus.wb_err_o;
    assign rdata[g]      = bus.wb_data_o;
    wb_sram_slave #(
      .ADDR_WIDTH  (12),
      .WAIT_STATES (WS),
      .MEMORY_FILE ("")
    ) u_dut (
      .sys_clk (clk),
      .rst_n   (rst_n),
      .wb      (bus.slave)
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut=%0d got=%h want=%h", name, d, act, req);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack[i] || err[i]) begin
        check("back_to_back_resp", i, {31'b0, prev_resp[i]}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp dut=%0d got ack=%b err=%b want none", i, ack[i], err[i]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_dut", i, 32'(i), 32'(e.dut));
          check("resp_kind", i, {30'b0, ack[i], err[i]}, {30'b0, ~e.is_err, e.is_err});
          check("resp_data", i, rdata[i], e.data);
          check("resp_cycle", i, 32'(cycle), 32'(e.at));
        end
      end
      prev_resp[i] <= ack[i] | err[i];
    end
  end

  task automatic push(input int d, input bit e_err, input logic [31:0] e_data, input int at);
    exp_t e;
    e.dut = d; e.is_err = e_err; e.data = e_data; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack[d] || err[d]) && n < 40);
    if (!(ack[d] || err[d])) begin
      total++;
      bad++;
      $display("FAIL resp_timeout dut=%0d got=none want=ack_or_err", d);
    end
  endtask

  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, input bit e_err, input logic [31:0] e_data);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wdata[d] = wd;
    push(d, e_err, e_data, cycle + 1 + ws_of(d));
    wait_resp(d);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 3; i++) begin
      sel[i] = '0; addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_ack", i, {31'b0, ack[i]}, 32'd0);
      check("reset_err", i, {31'b0, err[i]}, 32'd0);
      check("reset_data", i, rdata[i], 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // one wait state: basic write/read, byte lanes, out of range, sel=0, misaligned
    xfer(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    xfer(0, 0, 32'h10, 4'hF, 32'h0, 0, 32'hDEADBEEF);
    xfer(0, 1, 32'h20, 4'hF, 32'h11223344, 0, 32'h11223344);
    xfer(0, 1, 32'h20, 4'b0101, 32'hAABBCCDD, 0, 32'h11BB33DD);
    xfer(0, 0, 32'h20, 4'hF, 32'h0, 0, 32'h11BB33DD);
    xfer(0, 1, 32'h0, 4'hF, 32'hA5A5A5A5, 0, 32'hA5A5A5A5);
    xfer(0, 0, 32'h00004000, 4'hF, 32'h0, 1, 32'h0);
    xfer(0, 1, 32'h00004000, 4'hF, 32'hFFFFFFFF, 1, 32'h0);
    xfer(0, 0, 32'h0, 4'hF, 32'h0, 0, 32'hA5A5A5A5);
    xfer(0, 1, 32'h10, 4'h0, 32'h0, 0, 32'hDEADBEEF);
    xfer(0, 0, 32'h13, 4'h1, 32'h0, 0, 32'hDEADBEEF);
    xfer(0, 0, 32'h80000010, 4'hF, 32'h0, 1, 32'h0);

    // zero wait states: fill four words, then stream reads with stb held high
    for (int k = 0; k < 4; k++)
      xfer(1, 1, 32'(4 * k), 4'hF, 32'h10000000 + 32'(k * 32'h11), 0, 32'h10000000 + 32'(k * 32'h11));
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF;
    base = cycle + 1;
    for (int k = 0; k < 4; k++) begin
      addr[1] = 32'(4 * k);
      push(1, 0, 32'h10000000 + 32'(k * 32'h11), base + 2 * k);
      wait_resp(1);
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);

    // three wait states: abort by dropping cyc during WAIT
    xfer(2, 1, 32'h8, 4'hF, 32'h12345678, 0, 32'h12345678);
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h8; sel[2] = 4'hF; wdata[2] = 32'h55;
    @(negedge clk);
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    repeat (8) @(negedge clk);
    xfer(2, 0, 32'h8, 4'hF, 32'h0, 0, 32'h12345678);

    // asynchronous reset while a write sits in WAIT
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h8; sel[2] = 4'hF; wdata[2] = 32'hCAFEF00D;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ack", 2, {31'b0, ack[2]}, 32'd0);
    check("async_reset_err", 2, {31'b0, err[2]}, 32'd0);
    check("async_reset_data", 2, rdata[2], 32'd0);
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(2, 0, 32'h8, 4'hF, 32'h0, 0, 32'h12345678);

    repeat (6) @(negedge clk);
    check("queue_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
